// File: rtl/fp8_mul_pipe_pkg.sv
// Shared FP8 (1/3/4, hidden-one) format definitions for the multiplier and adder stages.
package fp8_mul_pipe_pkg;

  localparam int unsigned EXP_W     = 3;
  localparam int unsigned FRAC_W    = 4;
  localparam int unsigned SIG_W     = FRAC_W + 1;
  localparam int unsigned PROD_W    = 2 * SIG_W;
  localparam int unsigned EXP_SUM_W = 6;
  localparam int          FP8_BIAS  = 3;

  localparam logic [EXP_W-1:0] EXP_SAT  = 3'b111;
  localparam logic [7:0]       FP8_ZERO = 8'h00;

  localparam logic signed [EXP_SUM_W-1:0] EXP_OVF = 6'sd7;

  typedef struct packed {
    logic zero;
    logic sat;
  } fp8_class_t;

  function automatic fp8_class_t fp8_classify(input logic [7:0] v);
    fp8_class_t c;
    c.zero = (v[6:0] == 7'd0);
    c.sat  = (v[6:4] == EXP_SAT);
    return c;
  endfunction

  function automatic logic [7:0] fp8_sat(input logic s);
    return {s, EXP_SAT, {FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp8_mul_norm.sv
// Combinational last-stage logic: normalise the significand product, truncate and pack,
// applying zero, saturation and underflow rules.
module fp8_mul_norm
  import fp8_mul_pipe_pkg::*;
(
  input  logic                 i_sign,
  input  logic                 i_zero,
  input  logic                 i_sat,
  input  logic [PROD_W-1:0]    i_prod,
  input  logic [EXP_SUM_W-1:0] i_exp,
  output logic [7:0]           o_p,
  output logic                 o_ovf,
  output logic                 o_unf
);

  logic                        w_norm;
  logic [FRAC_W-1:0]           w_frac;
  logic signed [EXP_SUM_W-1:0] w_exp;
  logic                        w_neg;

  // Low product bits always fall below the truncation point.
  logic w_unused_prod;
  assign w_unused_prod = ^i_prod[3:0];

  always_comb begin
    w_norm = i_prod[PROD_W-1];
    w_frac = w_norm ? i_prod[8:5] : i_prod[7:4];
    w_exp  = $signed(i_exp) + (w_norm ? 6'sd1 : 6'sd0);
    w_neg  = w_exp[EXP_SUM_W-1];

    o_p   = FP8_ZERO;
    o_ovf = 1'b0;
    o_unf = 1'b0;
    if (i_zero) begin
      o_p = FP8_ZERO;
    end else if (i_sat || (!w_neg && (w_exp >= EXP_OVF))) begin
      o_p   = fp8_sat(i_sign);
      o_ovf = 1'b1;
    end else if (w_neg || ((w_exp == '0) && (w_frac == '0))) begin
      o_unf = 1'b1;
    end else begin
      o_p = {i_sign, w_exp[EXP_W-1:0], w_frac};
    end
  end

endmodule

// File: rtl/fp8_mul_pipe.sv
// Three-stage FP8 multiplier with valid/ready handshake; the whole pipe stalls as one
// when the output is held by the downstream stage.
module fp8_mul_pipe
  import fp8_mul_pipe_pkg::*;
#(
  parameter int BIAS = FP8_BIAS
) (
  input  logic       clkn,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] p,
  output logic       ovf,
  output logic       unf
);

  logic w_adv;

  logic       r_v1;
  logic [7:0] r_a1;
  logic [7:0] r_b1;
  fp8_class_t r_cls_a1;
  fp8_class_t r_cls_b1;

  logic                 r_v2;
  logic                 r_sign2;
  logic                 r_zero2;
  logic                 r_sat2;
  logic [PROD_W-1:0]    r_prod2;
  logic [EXP_SUM_W-1:0] r_exp2;

  logic       r_v3;
  logic [7:0] r_p;
  logic       r_ovf;
  logic       r_unf;

  logic [PROD_W-1:0]    w_prod;
  logic [EXP_SUM_W-1:0] w_exp_sum;
  logic [7:0]           w_p;
  logic                 w_ovf;
  logic                 w_unf;

  // Only a held, unconsumed result blocks the pipe; bubbles are not squeezed out.
  assign w_adv    = !r_v3 || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clkn or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clkn) begin
    if (w_adv && in_valid) begin
      r_a1     <= a;
      r_b1     <= b;
      r_cls_a1 <= fp8_classify(a);
      r_cls_b1 <= fp8_classify(b);
    end
  end

  always_comb begin
    w_prod    = PROD_W'({1'b1, r_a1[FRAC_W-1:0]}) * PROD_W'({1'b1, r_b1[FRAC_W-1:0]});
    w_exp_sum = EXP_SUM_W'(r_a1[6:4]) + EXP_SUM_W'(r_b1[6:4]) - EXP_SUM_W'(BIAS);
  end

  always_ff @(posedge clkn) begin
    if (w_adv && r_v1) begin
      r_sign2 <= r_a1[7] ^ r_b1[7];
      r_zero2 <= r_cls_a1.zero || r_cls_b1.zero;
      r_sat2  <= r_cls_a1.sat || r_cls_b1.sat;
      r_prod2 <= w_prod;
      r_exp2  <= w_exp_sum;
    end
  end

  fp8_mul_norm u_norm (
    .i_sign (r_sign2),
    .i_zero (r_zero2),
    .i_sat  (r_sat2),
    .i_prod (r_prod2),
    .i_exp  (r_exp2),
    .o_p    (w_p),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

  always_ff @(posedge clkn or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= FP8_ZERO;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_adv && r_v2) begin
      r_p   <= w_p;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end

  assign out_valid = r_v3;
  assign p         = r_p;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_fp8_mul_pipe.sv
// Self-checking bench for fp8_mul_pipe: directed spec vectors, backpressure, reset and
// random traffic against a real-arithmetic reference model.
module tb_fp8_mul_pipe;

  localparam int TbBias = 3;

  logic       clkn = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       ovf;
  logic       unf;

  int n_total = 0;
  int n_bad   = 0;

  logic [9:0] exp_q[$];

  always #5 clkn = ~clkn;

  fp8_mul_pipe #(
    .BIAS (TbBias)
  ) dut (
    .clkn      (clkn),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: {p, ovf, unf} from the value-level definition of the format.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
    logic s;
    int   e;
    int   frac;
    real  m;
    if (x[6:0] == 7'd0 || y[6:0] == 7'd0) return 10'b0;
    s = x[7] ^ y[7];
    if (x[6:4] == 3'd7 || y[6:4] == 3'd7) return {s, 7'b1110000, 2'b10};
    m = (1.0 + real'(int'(x[3:0])) / 16.0) * (1.0 + real'(int'(y[3:0])) / 16.0);
    e = int'(x[6:4]) + int'(y[6:4]) - TbBias;
    if (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    frac = int'($floor((m - 1.0) * 16.0));
    if (e >= 7) return {s, 7'b1110000, 2'b10};
    if (e < 0 || (e == 0 && frac == 0)) return 10'b0000000001;
    return {s, 3'(e), 4'(frac), 2'b00};
  endfunction

  function automatic logic [7:0] rand_op();
    logic [7:0] v;
    int unsigned r;
    v = 8'($urandom_range(0, 255));
    r = $urandom_range(0, 9);
    if (r == 0) v[6:0] = 7'd0;
    else if (r == 1) v[6:4] = 3'd7;
    return v;
  endfunction

  // One operand pair; out_valid must rise on the third rising edge counting the accept edge.
  task automatic run_pair(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [9:0] want);
    @(negedge clkn);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clkn);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clkn);
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(negedge clkn);
    check({tag, "_lat3"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, 32'({p, ovf, unf}), 32'(want));
    check({tag, "_flags"}, 32'(ovf & unf), 32'd0);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len, input bit rnd);
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    bit         was_stall = 1'b0;
    logic [9:0] held = '0;
    logic [9:0] want;
    exp_q.delete();
    while (got < n && cyc < 5000) begin
      @(negedge clkn);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        in_valid = 1'b1;
        a        = rand_op();
        b        = rand_op();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (was_stall) begin
        check({tag, "_hold"}, 32'({out_valid, p, ovf, unf}), 32'({1'b1, held}));
      end
      was_stall = out_valid && !out_ready;
      held      = {p, ovf, unf};
      if (was_stall) check({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra"}, 32'(got), 32'(n));
        end else begin
          want = exp_q.pop_front();
          check({tag, "_res"}, 32'({p, ovf, unf}), 32'(want));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        sent++;
      end
      cyc++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clkn);
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h00;
    b         = 8'h00;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clkn);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'h00);
    check("rst_flags", 32'({ovf, unf}), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clkn);

    run_pair("b_1p5sq", 8'h38, 8'h38, {8'h42, 2'b00});
    run_pair("b_neg", 8'h40, 8'hB0, {8'hC0, 2'b00});
    run_pair("t_3f", 8'h3F, 8'h3F, {8'h4E, 2'b00});
    run_pair("t_30", 8'h30, 8'h30, {8'h30, 2'b00});
    run_pair("ovf_60", 8'h60, 8'h60, {8'h70, 2'b10});
    run_pair("unf_10", 8'h10, 8'h10, {8'h00, 2'b01});
    run_pair("zero_a", 8'h00, 8'hB8, {8'h00, 2'b00});
    run_pair("zero_sat", 8'h70, 8'h00, {8'h00, 2'b00});
    run_pair("sat_in", 8'hF5, 8'h31, {8'hF0, 2'b10});
    run_pair("unf_e0f0", 8'h10, 8'h20, {8'h00, 2'b01});
    run_pair("e0_frac", 8'h18, 8'h20, {8'h08, 2'b00});

    run_stream("bp", 6, 3, 4, 1'b0);

    // Reset with two products in flight.
    @(negedge clkn);
    in_valid = 1'b1;
    a        = 8'h38;
    b        = 8'h38;
    @(negedge clkn);
    a = 8'h40;
    b = 8'h40;
    @(negedge clkn);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_p", 32'(p), 32'h00);
    @(negedge clkn);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clkn);
      check("post_rst_stale", 32'(out_valid), 32'd0);
    end
    run_pair("post_rst", 8'h3F, 8'h3F, {8'h4E, 2'b00});

    run_stream("rnd", 300, -1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
